// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer (mdu_seq).
// The optional signed mode is enabled with the MDU_SIGNED_EN macro.
package mdu_seq_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_DIVU  = 2'b01,
        MDU_MULT  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result and borrowed-ALU signals between the CPU and mdu_seq.
// The master side is the CPU datapath, which also owns the shared ALU.
interface mdu_seq_if #(
    parameter int XLEN = mdu_seq_pkg::MDU_XLEN
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            alu_req;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_carryout;

    modport master (
        output start, op, src_a, src_b, flush, alu_result, alu_carryout,
        input  busy, done, hi, lo, alu_req, alu_a, alu_b, alu_op
    );

    modport slave (
        input  start, op, src_a, src_b, flush, alu_result, alu_carryout,
        output busy, done, hi, lo, alu_req, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Sign handling for mdu_seq: operand magnitudes in, sign-corrected result out.
// Only built when MDU_SIGNED_EN is defined.
`ifdef MDU_SIGNED_EN
module mdu_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic              signed_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic              sign_a_o,
    output logic              sign_b_o,
    input  logic [2*XLEN-1:0] res_i,
    input  logic              mul_i,
    input  logic              neg_hi_i,
    input  logic              neg_lo_i,
    output logic [2*XLEN-1:0] res_o
);
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    assign sign_a_o = signed_i & a_i[XLEN-1];
    assign sign_b_o = signed_i & b_i[XLEN-1];
    assign mag_a_o  = sign_a_o ? -a_i : a_i;
    assign mag_b_o  = sign_b_o ? -b_i : b_i;

    assign res_hi = res_i[2*XLEN-1:XLEN];
    assign res_lo = res_i[XLEN-1:0];

    // A product negates as one 64-bit value; quotient and remainder negate independently.
    assign res_o = mul_i ? (neg_lo_i ? -res_i : res_i)
                         : {(neg_hi_i ? -res_hi : res_hi), (neg_lo_i ? -res_lo : res_lo)};
endmodule
`endif

// File: rtl/mdu_seq.sv
// Iterative shift-add multiplier / restoring divider that borrows the shared CPU ALU.
// Define MDU_SIGNED_EN to make MULT/DIV signed; otherwise op[1] is ignored.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic     clk,
    input  logic     resetn,
    mdu_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   wlo_q, wlo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              alu_req_q, alu_req_d;

    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   trial;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   step_acc, step_lo;
    logic [2*XLEN-1:0] fixed_res;
    logic              run;

    assign run   = (state_q == ST_RUN);
    assign trial = {acc_q[XLEN-2:0], wlo_q[XLEN-1]};

    assign bus.alu_a   = run ? (is_div_q ? trial : acc_q) : '0;
    assign bus.alu_b   = run ? opb_q : '0;
    assign bus.alu_op  = (run && is_div_q) ? ALU_SUB : ALU_ADD;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.alu_req = alu_req_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

    // One iteration, using whatever the ALU returned for this cycle's operands.
    always_comb begin
        mul_sum  = wlo_q[0] ? {bus.alu_carryout, bus.alu_result} : {1'b0, acc_q};
        step_acc = mul_sum[XLEN:1];
        step_lo  = {mul_sum[0], wlo_q[XLEN-1:1]};
        if (is_div_q) begin
            // msb set means the shifted remainder exceeds XLEN bits, so it always fits.
            if (acc_q[XLEN-1] | ~bus.alu_carryout) begin
                step_acc = bus.alu_result;
                step_lo  = {wlo_q[XLEN-2:0], 1'b1};
            end else begin
                step_acc = trial;
                step_lo  = {wlo_q[XLEN-2:0], 1'b0};
            end
        end
    end

`ifdef MDU_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_hi_q, neg_hi_d;
    logic neg_lo_q, neg_lo_d;

    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .signed_i (bus.op[1]),
        .a_i      (bus.src_a),
        .b_i      (bus.src_b),
        .mag_a_o  (mag_a),
        .mag_b_o  (mag_b),
        .sign_a_o (sign_a),
        .sign_b_o (sign_b),
        .res_i    ({step_acc, step_lo}),
        .mul_i    (~is_div_q),
        .neg_hi_i (neg_hi_q),
        .neg_lo_i (neg_lo_q),
        .res_o    (fixed_res)
    );
`else
    logic unused_op_sign;
    assign unused_op_sign = bus.op[1];
    assign mag_a     = bus.src_a;
    assign mag_b     = bus.src_b;
    assign fixed_res = {step_acc, step_lo};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        wlo_d    = wlo_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
`ifdef MDU_SIGNED_EN
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    is_div_d = bus.op[0];
                    cnt_d    = '0;
                    acc_d    = '0;
`ifdef MDU_SIGNED_EN
                    neg_hi_d = bus.op[0] ? sign_a : (sign_a ^ sign_b);
                    neg_lo_d = sign_a ^ sign_b;
`endif
                    if (!bus.op[0]) begin
                        wlo_d   = mag_b;
                        opb_d   = mag_a;
                        state_d = ST_RUN;
                    end else if (bus.src_b == '0) begin
                        hi_d    = bus.src_a;
                        lo_d    = '1;
                        state_d = ST_DONE;
                    end else begin
                        wlo_d   = mag_a;
                        opb_d   = mag_b;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    wlo_d = step_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        hi_d    = fixed_res[2*XLEN-1:XLEN];
                        lo_d    = fixed_res[XLEN-1:0];
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d    = (state_d == ST_RUN);
        alu_req_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            wlo_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_hi_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wlo_q     <= wlo_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_req_q <= alu_req_d;
`ifdef MDU_SIGNED_EN
            neg_hi_q  <= neg_hi_d;
            neg_lo_q  <= neg_lo_d;
`endif
        end
    end

endmodule
